// File: rtl/axi_pim_pkg.sv
// axi_pim_pkg: shared FSM states, AXI constants and response helper for the PIM master
package axi_pim_pkg;
  typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_B, S_AR, S_R} state_t;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [3:0] AXI_CACHE_DEFAULT = 4'b0011;
  function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/axi_pim_master_perf.sv
// axi_pim_master_perf: saturating busy-cycle and beat counters
module axi_pim_master_perf #(
  parameter int PERF_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  busy,
  input  logic                  beat,
  output logic [PERF_WIDTH-1:0] perf_busy_cycles,
  output logic [PERF_WIDTH-1:0] perf_beats
);
  // both counters stick at all-ones instead of wrapping
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      perf_busy_cycles <= '0;
      perf_beats <= '0;
    end else begin
      perf_busy_cycles <= busy && !(&perf_busy_cycles) ? perf_busy_cycles + PERF_WIDTH'(1) : perf_busy_cycles;
      perf_beats <= beat && !(&perf_beats) ? perf_beats + PERF_WIDTH'(1) : perf_beats;
    end
endmodule

// File: rtl/axi_pim_master.sv
// axi_pim_master: single-outstanding AXI4 INCR burst master; AXI_PIM_MASTER_PERF_EN adds perf counters
module axi_pim_master
  import axi_pim_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int ID_WIDTH = 8
`ifdef AXI_PIM_MASTER_PERF_EN
  , parameter int PERF_WIDTH = 32
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [7:0]            cmd_len,
  input  logic [ID_WIDTH-1:0]   cmd_id,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [STRB_WIDTH-1:0] wr_strb,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_last,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic                  done_valid,
  output logic [1:0]            done_resp,
  output logic [ID_WIDTH-1:0]   m_axi_awid,
  output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [7:0]            m_axi_awlen,
  output logic [2:0]            m_axi_awsize,
  output logic [1:0]            m_axi_awburst,
  output logic                  m_axi_awlock,
  output logic [3:0]            m_axi_awcache,
  output logic [2:0]            m_axi_awprot,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [DATA_WIDTH-1:0] m_axi_wdata,
  output logic [STRB_WIDTH-1:0] m_axi_wstrb,
  output logic                  m_axi_wlast,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [ID_WIDTH-1:0]   m_axi_bid,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  output logic [ID_WIDTH-1:0]   m_axi_arid,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arlock,
  output logic [3:0]            m_axi_arcache,
  output logic [2:0]            m_axi_arprot,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [ID_WIDTH-1:0]   m_axi_rid,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
`ifdef AXI_PIM_MASTER_PERF_EN
  ,
  output logic [PERF_WIDTH-1:0] perf_busy_cycles,
  output logic [PERF_WIDTH-1:0] perf_beats
`endif
);
  localparam int SIZE = $clog2(STRB_WIDTH);
  state_t state_q, state_d;
  logic [ID_WIDTH-1:0] id_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [7:0] len_q, beat_q;
  logic [1:0] resp_q, done_resp_d;
  logic err_q, done_d;
  logic [31:0] end_off;
  assign end_off = 32'(cmd_addr[11:0]) + (32'(cmd_len) + 32'd1) * 32'(STRB_WIDTH);
  wire bad_cmd = end_off > 32'd4096 || (cmd_addr & ADDR_WIDTH'(STRB_WIDTH - 1)) != '0;
  wire cmd_fire = cmd_valid && cmd_ready;
  wire last = beat_q == len_q;
  wire w_fire = m_axi_wvalid && m_axi_wready;
  wire r_fire = m_axi_rvalid && m_axi_rready;
  wire r_bad = m_axi_rlast != last || m_axi_rid != id_q;
  assign m_axi_awid = id_q;
  assign m_axi_awaddr = addr_q;
  assign m_axi_awlen = len_q;
  assign m_axi_awsize = 3'(SIZE);
  assign m_axi_awburst = AXI_BURST_INCR;
  assign m_axi_awlock = 1'b0;
  assign m_axi_awcache = AXI_CACHE_DEFAULT;
  assign m_axi_awprot = 3'b000;
  assign m_axi_awvalid = state_q == S_AW;
  assign m_axi_wdata = wr_data;
  assign m_axi_wstrb = wr_strb;
  assign m_axi_wlast = last;
  assign m_axi_wvalid = state_q == S_W && wr_valid;
  assign wr_ready = state_q == S_W && m_axi_wready;
  assign m_axi_bready = state_q == S_B;
  assign m_axi_arid = id_q;
  assign m_axi_araddr = addr_q;
  assign m_axi_arlen = len_q;
  assign m_axi_arsize = 3'(SIZE);
  assign m_axi_arburst = AXI_BURST_INCR;
  assign m_axi_arlock = 1'b0;
  assign m_axi_arcache = AXI_CACHE_DEFAULT;
  assign m_axi_arprot = 3'b000;
  assign m_axi_arvalid = state_q == S_AR;
  assign m_axi_rready = state_q == S_R && rd_ready;
  assign rd_valid = state_q == S_R && m_axi_rvalid;
  assign rd_data = m_axi_rdata;
  assign rd_last = last;
  // state register; reset abandons any burst in flight
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= S_IDLE;
    else state_q <= state_d;
  // next state plus the completion decision for this cycle
  always_comb begin
    state_d = state_q;
    done_d = 1'b0;
    done_resp_d = AXI_RESP_SLVERR;
    case (state_q)
      S_IDLE: begin
        state_d = !cmd_fire || bad_cmd ? S_IDLE : cmd_write ? S_AW : S_AR;
        done_d = cmd_fire && bad_cmd;
      end
      S_AW: state_d = m_axi_awready ? S_W : S_AW;
      S_W: state_d = w_fire && last ? S_B : S_W;
      S_B: begin
        state_d = m_axi_bvalid ? S_IDLE : S_B;
        done_d = m_axi_bvalid;
        done_resp_d = m_axi_bid != id_q ? AXI_RESP_SLVERR : m_axi_bresp;
      end
      S_AR: state_d = m_axi_arready ? S_R : S_AR;
      S_R: begin
        state_d = r_fire && last ? S_IDLE : S_R;
        done_d = r_fire && last;
        done_resp_d = err_q || r_bad ? AXI_RESP_SLVERR : resp_max(resp_q, m_axi_rresp);
      end
      default: state_d = S_IDLE;
    endcase
  end
  // command latch, beat counter, read response accumulation and registered handshakes
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cmd_ready <= 1'b0;
      done_valid <= 1'b0;
      done_resp <= AXI_RESP_OKAY;
      id_q <= '0;
      addr_q <= '0;
      len_q <= '0;
      beat_q <= '0;
      resp_q <= AXI_RESP_OKAY;
      err_q <= 1'b0;
    end else begin
      cmd_ready <= state_d == S_IDLE && !done_d;
      done_valid <= done_d;
      done_resp <= done_d ? done_resp_d : done_resp;
      if (cmd_fire) begin
        id_q <= cmd_id;
        addr_q <= cmd_addr;
        len_q <= cmd_len;
        beat_q <= '0;
        resp_q <= AXI_RESP_OKAY;
        err_q <= 1'b0;
      end else if (w_fire || r_fire) beat_q <= beat_q + 8'd1;
      if (r_fire) begin
        resp_q <= resp_max(resp_q, m_axi_rresp);
        err_q <= err_q || r_bad;
      end
    end
`ifdef AXI_PIM_MASTER_PERF_EN
  axi_pim_master_perf #(.PERF_WIDTH(PERF_WIDTH)) u_perf (
    .clk(clk),
    .rst(rst),
    .busy(state_q != S_IDLE),
    .beat(w_fire || r_fire),
    .perf_busy_cycles(perf_busy_cycles),
    .perf_beats(perf_beats)
  );
`endif
endmodule

// File: tb/tb_axi_pim_master.sv
// tb_axi_pim_master: directed bench with a reactive AXI slave model; AXI_PIM_MASTER_PERF_EN enables perf checks
module tb_axi_pim_master;
  logic clk = 1'b0, rst = 1'b1;
  logic cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [15:0] cmd_addr = '0;
  logic [7:0] cmd_len = '0, cmd_id = '0;
  logic [31:0] wr_data, rd_data;
  logic [3:0] wr_strb;
  logic wr_valid, wr_ready, rd_last, rd_valid, rd_ready, done_valid;
  logic [1:0] done_resp;
  logic [7:0] m_axi_awid, m_axi_awlen, m_axi_bid, m_axi_arid, m_axi_arlen, m_axi_rid;
  logic [15:0] m_axi_awaddr, m_axi_araddr;
  logic [2:0] m_axi_awsize, m_axi_awprot, m_axi_arsize, m_axi_arprot;
  logic [1:0] m_axi_awburst, m_axi_arburst, m_axi_bresp, m_axi_rresp;
  logic m_axi_awlock, m_axi_awvalid, m_axi_awready, m_axi_wlast, m_axi_wvalid, m_axi_wready;
  logic m_axi_bvalid, m_axi_bready, m_axi_arlock, m_axi_arvalid, m_axi_arready;
  logic m_axi_rlast, m_axi_rvalid, m_axi_rready;
  logic [3:0] m_axi_awcache, m_axi_arcache, m_axi_wstrb;
  logic [31:0] m_axi_wdata, m_axi_rdata;
`ifdef AXI_PIM_MASTER_PERF_EN
  logic [31:0] perf_busy_cycles, perf_beats;
`endif
  always #5 clk = ~clk;
  axi_pim_master dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_id(cmd_id), .wr_data(wr_data), .wr_strb(wr_strb),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .rd_data(rd_data), .rd_last(rd_last), .rd_valid(rd_valid),
    .rd_ready(rd_ready), .done_valid(done_valid), .done_resp(done_resp),
    .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
    .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock), .m_axi_awcache(m_axi_awcache),
    .m_axi_awprot(m_axi_awprot), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast), .m_axi_wvalid(m_axi_wvalid),
    .m_axi_wready(m_axi_wready), .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready), .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
    .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot), .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready), .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
`ifdef AXI_PIM_MASTER_PERF_EN
    , .perf_busy_cycles(perf_busy_cycles), .perf_beats(perf_beats)
`endif
  );
  int n_checks = 0, n_fail = 0;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  bit rnd = 0, bad_bid = 0, bad_rlast = 0;
  int aw_stall = 0, rresp_sl_beat = -1;
  logic [31:0] mem [0:16383];
  logic [31:0] wr_q[$], exp_q[$];
  logic [15:0] cur_addr = '0;
  logic [7:0] cur_len = '0, cur_id = '0;
  int w_beats = 0, r_beats = 0, axi_seen = 0;
  function automatic int widx(input logic [15:0] a, input int c);
    return (int'(a >> 2) + c) & 16383;
  endfunction
  // reactive slave, write source and read sink: sample at negedge, drive 1 time unit after posedge
  initial begin
    bit hs_aw, hs_w, hs_b, hs_ar, hs_r, hs_src, b_pend, r_act;
    int aw_wait, wc, rc;
    logic [15:0] s_waddr, s_raddr;
    logic [7:0] s_rlen, s_wid, s_rid;
    logic [31:0] e;
    b_pend = 0; r_act = 0; aw_wait = 0; wc = 0; rc = 0;
    s_waddr = '0; s_raddr = '0; s_rlen = '0; s_wid = '0; s_rid = '0;
    m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_bid = '0; m_axi_bresp = '0;
    m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rid = '0; m_axi_rdata = '0; m_axi_rresp = '0; m_axi_rlast = 0;
    wr_valid = 0; wr_data = '0; wr_strb = '1; rd_ready = 0;
    forever begin
      @(negedge clk);
      hs_aw = m_axi_awvalid && m_axi_awready;
      hs_w = m_axi_wvalid && m_axi_wready;
      hs_b = m_axi_bvalid && m_axi_bready;
      hs_ar = m_axi_arvalid && m_axi_arready;
      hs_r = m_axi_rvalid && m_axi_rready;
      hs_src = wr_valid && wr_ready;
      if (!rst) begin
        if (m_axi_awvalid || m_axi_arvalid) axi_seen++;
        if (m_axi_awvalid)
          check("aw_fields", {m_axi_awaddr, m_axi_awlen, m_axi_awid, m_axi_awsize, m_axi_awburst, m_axi_awlock, m_axi_awcache, m_axi_awprot},
                {cur_addr, cur_len, cur_id, 3'd2, 2'b01, 1'b0, 4'b0011, 3'b000});
        if (m_axi_arvalid)
          check("ar_fields", {m_axi_araddr, m_axi_arlen, m_axi_arid, m_axi_arsize, m_axi_arburst, m_axi_arlock, m_axi_arcache, m_axi_arprot},
                {cur_addr, cur_len, cur_id, 3'd2, 2'b01, 1'b0, 4'b0011, 3'b000});
        aw_wait = hs_aw ? 0 : m_axi_awvalid ? aw_wait + 1 : aw_wait;
        if (hs_aw) begin
          s_waddr = m_axi_awaddr; s_wid = m_axi_awid; wc = 0;
        end
        if (hs_src && wr_q.size() > 0) void'(wr_q.pop_front());
        if (hs_w) begin
          check("wlast", m_axi_wlast, wc == int'(cur_len));
          mem[widx(s_waddr, wc)] = m_axi_wdata;
          wc++; w_beats++;
          if (wc == int'(cur_len) + 1) b_pend = 1;
        end
        if (hs_b) b_pend = 0;
        if (hs_ar) begin
          s_raddr = m_axi_araddr; s_rlen = m_axi_arlen; s_rid = m_axi_arid; rc = 0; r_act = 1;
        end
        if (hs_r) begin
          if (exp_q.size() > 0) e = exp_q.pop_front();
          else e = 32'hBAD0_BAD0;
          check("rd_data", rd_data, e);
          check("rd_last", rd_last, rc == int'(cur_len));
          rc++; r_beats++;
          if (rc > int'(s_rlen)) r_act = 0;
        end
      end
      @(posedge clk);
      #1;
      if (rst) begin
        b_pend = 0; r_act = 0; aw_wait = 0; wc = 0; rc = 0;
        m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rlast = 0;
        wr_valid = 0; rd_ready = 0;
      end else begin
        m_axi_awready = rnd ? 1'($urandom_range(0, 1)) : aw_wait >= aw_stall;
        m_axi_wready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        wr_valid = wr_q.size() > 0 && ((wr_valid && !hs_src) || !rnd || $urandom_range(0, 1) == 1);
        wr_data = wr_q.size() > 0 ? wr_q[0] : '0;
        m_axi_bvalid = b_pend && (m_axi_bvalid || !rnd || $urandom_range(0, 1) == 1);
        m_axi_bid = bad_bid ? ~s_wid : s_wid;
        m_axi_bresp = 2'b00;
        m_axi_arready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        m_axi_rvalid = r_act && ((m_axi_rvalid && !hs_r) || !rnd || $urandom_range(0, 1) == 1);
        m_axi_rdata = mem[widx(s_raddr, rc)];
        m_axi_rlast = rc == int'(s_rlen) && !bad_rlast;
        m_axi_rresp = rc == rresp_sl_beat ? 2'b10 : 2'b00;
        m_axi_rid = s_rid;
        rd_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      end
    end
  end
  // issue one command, wait for its completion pulse and check response, latency and beat count
  task automatic do_cmd(input bit wr, input logic [15:0] addr, input logic [7:0] len, input logic [7:0] id,
                        input logic [1:0] exp_resp, input int exp_lat, input int exp_beats, input string tag);
    int n, b0;
    @(negedge clk);
    cur_addr = addr; cur_len = len; cur_id = id;
    b0 = wr ? w_beats : r_beats;
    n = 0;
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    cmd_write = wr; cmd_addr = addr; cmd_len = len; cmd_id = id; cmd_valid = 1;
    @(posedge clk);
    #1 cmd_valid = 0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done_valid && n < 20000);
    if (!done_valid) check({tag, "_timeout"}, 1, 0);
    check({tag, "_resp"}, done_resp, exp_resp);
    if (exp_lat >= 0) check({tag, "_lat"}, n, exp_lat);
    check({tag, "_beats"}, (wr ? w_beats : r_beats) - b0, exp_beats);
    @(negedge clk);
    check({tag, "_ready"}, cmd_ready, 1);
  endtask
  initial begin
    logic [31:0] v;
    int n, b0;
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_outs", {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready, wr_ready, rd_valid, done_valid, done_resp}, 0);
    rst = 0;
    #1 check("rel_ready_low", cmd_ready, 0);
    @(negedge clk);
    check("rel_ready_high", cmd_ready, 1);
    wr_q = '{32'h11, 32'h22, 32'h33, 32'h44};
    do_cmd(1, 16'h0040, 8'd3, 8'h05, 2'b00, -1, 4, "wr1");
    exp_q = '{32'h11, 32'h22, 32'h33, 32'h44};
    do_cmd(0, 16'h0040, 8'd3, 8'h06, 2'b00, -1, 4, "rd1");
    check("rd1_drain", exp_q.size(), 0);
    n = axi_seen;
    do_cmd(1, 16'h0FF8, 8'd3, 8'h07, 2'b10, 1, 0, "x4k_wr");
    do_cmd(0, 16'h0FF8, 8'd3, 8'h07, 2'b10, 1, 0, "x4k_rd");
    do_cmd(1, 16'h0042, 8'd0, 8'h07, 2'b10, 1, 0, "misal");
    check("err_no_axi", axi_seen - n, 0);
    wr_q = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
    do_cmd(1, 16'h0FF0, 8'd3, 8'h08, 2'b00, -1, 4, "edge4k");
    wr_q = '{32'hDEADBEEF};
    do_cmd(1, 16'h0100, 8'd0, 8'h09, 2'b00, -1, 1, "wr_len0");
    exp_q = '{32'hDEADBEEF};
    do_cmd(0, 16'h0100, 8'd0, 8'h0A, 2'b00, -1, 1, "rd_len0");
    bad_bid = 1;
    wr_q = '{32'hC0, 32'hC1};
    do_cmd(1, 16'h0200, 8'd1, 8'h0B, 2'b10, -1, 2, "bid_bad");
    bad_bid = 0;
    rresp_sl_beat = 1;
    exp_q = '{32'hC0, 32'hC1};
    do_cmd(0, 16'h0200, 8'd1, 8'h0C, 2'b10, -1, 2, "rresp_worst");
    rresp_sl_beat = -1;
    bad_rlast = 1;
    exp_q = '{32'hC0, 32'hC1};
    do_cmd(0, 16'h0200, 8'd1, 8'h0D, 2'b10, -1, 2, "rlast_bad");
    bad_rlast = 0;
    rnd = 1;
    for (int i = 0; i < 256; i++) begin
      v = $urandom;
      wr_q.push_back(v);
      exp_q.push_back(v);
    end
    do_cmd(1, 16'h0400, 8'd255, 8'h11, 2'b00, -1, 256, "wr256");
    do_cmd(0, 16'h0400, 8'd255, 8'h12, 2'b00, -1, 256, "rd256");
    check("rd256_drain", exp_q.size(), 0);
    rnd = 0;
    for (int i = 0; i < 8; i++) wr_q.push_back(32'h500 + 32'(i));
    @(negedge clk);
    cur_addr = 16'h0500; cur_len = 8'd7; cur_id = 8'h13;
    b0 = w_beats;
    cmd_write = 1; cmd_addr = 16'h0500; cmd_len = 8'd7; cmd_id = 8'h13; cmd_valid = 1;
    @(posedge clk);
    #1 cmd_valid = 0;
    n = 0;
    while (w_beats - b0 < 2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("midw_reached", w_beats - b0 >= 2, 1);
    #2 rst = 1;
    #1 check("midw_rst_outs", {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready, wr_ready, rd_valid, done_valid, cmd_ready}, 0);
    wr_q.delete();
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 0;
    #1 check("midw_rel_low", cmd_ready, 0);
    @(negedge clk);
    check("midw_rel_high", cmd_ready, 1);
    exp_q = '{32'h11, 32'h22, 32'h33, 32'h44};
    do_cmd(0, 16'h0040, 8'd3, 8'h14, 2'b00, -1, 4, "rd_after_rst");
`ifdef AXI_PIM_MASTER_PERF_EN
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    check("perf_clr", {perf_busy_cycles, perf_beats}, 0);
    aw_stall = 2;
    wr_q = '{32'h1, 32'h2};
    do_cmd(1, 16'h0300, 8'd1, 8'h15, 2'b00, -1, 2, "perf_wr");
    aw_stall = 0;
    check("perf_beats", perf_beats, 2);
    check("perf_busy", perf_busy_cycles, 6);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
